// File: rtl/sata_tx_framer_if.sv
// Framer-side bundle: FIFO read port (async-read, no read-on-empty) plus the
// outbound valid/ready stream toward the link-layer primitive inserter.
interface sata_tx_framer_if;
    logic        o_fifo_rd;
    logic [31:0] i_fifo_data;
    logic        i_fifo_empty;
    logic        M_VALID;
    logic        i_m_ready;
    logic [31:0] M_DATA;
    logic        M_LAST;

    modport master (
        output o_fifo_rd, M_VALID, M_DATA, M_LAST,
        input  i_fifo_data, i_fifo_empty, i_m_ready
    );

    modport slave (
        input  o_fifo_rd, M_VALID, M_DATA, M_LAST,
        output i_fifo_data, i_fifo_empty, i_m_ready
    );
endinterface

// File: rtl/sata_tx_framer.sv
// Drains a commanded number of payload words from the TX FIFO onto a
// valid/ready stream and appends the SATA frame CRC-32 as the LAST beat.
module sata_tx_framer #(
    parameter int          LGMAXLEN = 13,
    parameter logic [31:0] CRC_INIT = 32'h52325032,
    parameter logic [31:0] CRC_POLY = 32'h04C11DB7
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_start,
    input  logic [LGMAXLEN-1:0] i_nwords,
    input  logic                i_abort,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_aborted,
    sata_tx_framer_if.master    bus
);

    typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

    state_t              state, nxt;
    logic [LGMAXLEN-1:0] remaining;
    logic [31:0]         crc;
    logic                load, xfer, done_ev, abort_ev, valid;

    // MSB-first, non-reflected CRC over a full 32-bit word in one cycle
    function automatic logic [31:0] next_crc(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 31; i >= 0; i--)
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
        return r;
    endfunction

    always_comb begin
        nxt           = state;
        load          = 1'b0;
        xfer          = 1'b0;
        done_ev       = 1'b0;
        abort_ev      = 1'b0;
        valid         = 1'b0;
        bus.M_DATA    = bus.i_fifo_data;
        bus.M_LAST    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start && !i_abort && (i_nwords != '0)) begin
                    nxt  = DATA;
                    load = 1'b1;
                end
            end
            DATA: begin
                if (i_abort) begin
                    nxt      = IDLE;
                    abort_ev = 1'b1;
                end else begin
                    // pop in the same cycle as the transfer: zero-bubble streaming
                    valid = !bus.i_fifo_empty;
                    xfer  = valid && bus.i_m_ready;
                    if (xfer && (remaining == LGMAXLEN'(1)))
                        nxt = CRC;
                end
            end
            CRC: begin
                bus.M_DATA = crc;
                if (i_abort) begin
                    nxt      = IDLE;
                    abort_ev = 1'b1;
                end else begin
                    valid      = 1'b1;
                    bus.M_LAST = 1'b1;
                    if (bus.i_m_ready) begin
                        nxt     = IDLE;
                        done_ev = 1'b1;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
        bus.M_VALID   = valid;
        bus.o_fifo_rd = xfer;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            crc       <= CRC_INIT;
            o_done    <= 1'b0;
            o_aborted <= 1'b0;
        end else begin
            state     <= nxt;
            o_done    <= done_ev;
            o_aborted <= abort_ev;
            if (load) begin
                remaining <= i_nwords;
                crc       <= CRC_INIT;
            end else if (xfer) begin
                remaining <= remaining - LGMAXLEN'(1);
                crc       <= next_crc(crc, bus.i_fifo_data);
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_sata_tx_framer.sv
// Directed/randomized bench: queue-backed FIFO model, beat monitor, and a
// polynomial-division CRC reference compared against the streamed frames.
module tb_sata_tx_framer;

    localparam logic [31:0] SEED = 32'h52325032;
    localparam logic [63:0] PFULL = 64'h1_04C1_1DB7;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [12:0] i_nwords = '0;
    logic        i_abort = 1'b0;
    logic        o_busy, o_done, o_aborted;
    logic        ready = 1'b1;

    sata_tx_framer_if bus ();

    sata_tx_framer #(.LGMAXLEN(13)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (i_start),
        .i_nwords  (i_nwords),
        .i_abort   (i_abort),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_aborted (o_aborted),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    // FIFO model: array with free-running pointers
    logic [31:0] mem [0:255];
    int          wrp = 0, rdp = 0;
    logic        flush = 1'b0;

    assign bus.i_fifo_empty = (rdp == wrp);
    assign bus.i_fifo_data  = mem[rdp[7:0]];
    assign bus.i_m_ready    = ready;

    always @(posedge i_clk) begin
        if (flush) rdp <= wrp;
        else if (bus.o_fifo_rd && (rdp != wrp)) rdp <= rdp + 1;
    end

    // Monitor
    logic [32:0] beats [$];
    int          beat_cyc [$];
    int          cyc = 0, rd_cnt = 0, done_cnt = 0, ab_cnt = 0, done_cyc = 0;
    int          stab_err = 0, idle_err = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;

    always @(posedge i_clk) begin
        if (bus.M_VALID && bus.i_m_ready) begin
            beats.push_back({bus.M_LAST, bus.M_DATA});
            beat_cyc.push_back(cyc);
        end
        if (prev_stall && bus.M_VALID && ({bus.M_LAST, bus.M_DATA} !== prev_beat))
            stab_err <= stab_err + 1;
        if (bus.M_VALID && !o_busy) idle_err <= idle_err + 1;
        if (bus.o_fifo_rd) rd_cnt <= rd_cnt + 1;
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (o_aborted) ab_cnt <= ab_cnt + 1;
        prev_stall <= bus.M_VALID && !bus.i_m_ready;
        prev_beat  <= {bus.M_LAST, bus.M_DATA};
        cyc        <= cyc + 1;
    end

    int checks = 0, errors = 0;
    logic [31:0] fr_words [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CRC as remainder of (crc ^ word) * x^32 modulo the generator
    function automatic logic [31:0] crc_model(input logic [31:0] w [$]);
        logic [31:0] c;
        logic [63:0] v;
        c = SEED;
        foreach (w[i]) begin
            v = {c ^ w[i], 32'h0};
            for (int b = 63; b >= 32; b--)
                if (v[b]) v = v ^ (PFULL << (b - 32));
            c = v[31:0];
        end
        return c;
    endfunction

    task automatic push(input logic [31:0] w);
        mem[wrp[7:0]] = w;
        wrp++;
    endtask

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_flush();
        @(negedge i_clk) flush = 1'b1;
        @(negedge i_clk) flush = 1'b0;
    endtask

    // mode: 0 always ready, 1 pattern 1,0,0, 2 random; gap>0 holds back words 2..n
    task automatic run_frame(input string tag, input int mode, input bit poke, input int gap);
        int n, d0, r0, scyc, k;
        logic [31:0] exp_crc;
        n = fr_words.size();
        exp_crc = crc_model(fr_words);
        for (int i = 0; i < n; i++) if (gap == 0 || i == 0) push(fr_words[i]);
        beats.delete();
        beat_cyc.delete();
        d0 = done_cnt;
        r0 = rd_cnt;
        @(negedge i_clk);
        scyc = cyc;
        k = 0;
        while (done_cnt == d0 && k < 2000) begin
            ready = ready_for(mode, k);
            i_start  = (k == 0) || (poke && k == 2);
            i_nwords = (k == 0) ? 13'(n) : 13'd5;
            if (gap > 0 && k == gap)
                for (int i = 1; i < n; i++) push(fr_words[i]);
            if (gap > 0 && k >= 2 && k < gap) begin
                #1;
                chk({tag, " gap valid"}, 32'(bus.M_VALID), 32'd0);
                chk({tag, " gap busy"}, 32'(o_busy), 32'd1);
            end
            @(negedge i_clk);
            k++;
        end
        i_start = 1'b0;
        ready = 1'b1;
        chk({tag, " done pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, " beat count"}, 32'(beats.size()), 32'(n + 1));
        if (beats.size() == n + 1) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, " payload"}, beats[i][31:0], fr_words[i]);
                chk({tag, " payload last"}, 32'(beats[i][32]), 32'd0);
            end
            chk({tag, " crc"}, beats[n][31:0], exp_crc);
            chk({tag, " crc last"}, 32'(beats[n][32]), 32'd1);
            chk({tag, " done timing"}, 32'(done_cyc), 32'(beat_cyc[n] + 1));
            if (mode == 0 && gap == 0) begin
                chk({tag, " first beat cycle"}, 32'(beat_cyc[0]), 32'(scyc + 1));
                chk({tag, " last beat cycle"}, 32'(beat_cyc[n]), 32'(scyc + 1 + n));
            end
        end
        chk({tag, " fifo pops"}, 32'(rd_cnt - r0), 32'(n));
        chk({tag, " fifo empty"}, 32'(wrp - rdp), 32'd0);
        @(negedge i_clk);
        chk({tag, " idle after"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int d0, a0, n;
        // reset state
        #2;
        chk("reset busy", 32'(o_busy), 32'd0);
        chk("reset valid", 32'(bus.M_VALID), 32'd0);
        chk("reset fifo_rd", 32'(bus.o_fifo_rd), 32'd0);
        chk("reset done", 32'(o_done), 32'd0);
        chk("reset aborted", 32'(o_aborted), 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // basic frame 1..4
        fr_words.delete();
        for (int i = 1; i <= 4; i++) fr_words.push_back(32'(i));
        run_frame("basic", 0, 1'b0, 0);

        // back-pressure, same payload, with a start poked mid-frame
        run_frame("backpressure", 1, 1'b1, 0);
        chk("backpressure stable", 32'(stab_err), 32'd0);

        // underrun: 1 word preloaded, 2 more 10 cycles later
        fr_words.delete();
        for (int i = 0; i < 3; i++) fr_words.push_back($urandom);
        run_frame("underrun", 0, 1'b0, 10);

        // random frames with random back-pressure
        for (int f = 0; f < 4; f++) begin
            fr_words.delete();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) fr_words.push_back($urandom);
            run_frame("random", 2, 1'b0, 0);
        end

        // zero-length start is ignored
        d0 = done_cnt;
        @(negedge i_clk);
        i_start = 1'b1;
        i_nwords = '0;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("zero start busy", 32'(o_busy), 32'd0);
        repeat (3) @(negedge i_clk);
        chk("zero start busy later", 32'(o_busy), 32'd0);
        chk("zero start no done", 32'(done_cnt - d0), 32'd0);

        // abort after the 3rd transfer of an 8-word frame
        fr_words.delete();
        for (int i = 0; i < 8; i++) begin
            fr_words.push_back($urandom);
            push(fr_words[i]);
        end
        beats.delete();
        a0 = ab_cnt;
        d0 = done_cnt;
        ready = 1'b1;
        i_start = 1'b1;
        i_nwords = 13'd8;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < 100 && beats.size() < 3; k++) @(negedge i_clk);
        chk("abort beats before", 32'(beats.size()), 32'd3);
        i_abort = 1'b1;
        #1;
        chk("abort valid forced", 32'(bus.M_VALID), 32'd0);
        chk("abort no pop", 32'(bus.o_fifo_rd), 32'd0);
        @(negedge i_clk);
        i_abort = 1'b0;
        chk("abort pulse", 32'(o_aborted), 32'd1);
        chk("abort busy", 32'(o_busy), 32'd0);
        chk("abort fifo left", 32'(wrp - rdp), 32'd5);
        repeat (3) @(negedge i_clk);
        chk("abort no more beats", 32'(beats.size()), 32'd3);
        chk("abort single pulse", 32'(ab_cnt - a0), 32'd1);
        chk("abort no done", 32'(done_cnt - d0), 32'd0);
        do_flush();

        // fresh frame after abort uses the seed again
        fr_words.delete();
        for (int i = 0; i < 2; i++) fr_words.push_back($urandom);
        run_frame("post abort", 2, 1'b0, 0);

        // asynchronous reset mid-frame
        fr_words.delete();
        for (int i = 0; i < 6; i++) push($urandom);
        beats.delete();
        a0 = ab_cnt;
        d0 = done_cnt;
        ready = 1'b1;
        i_start = 1'b1;
        i_nwords = 13'd6;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < 100 && beats.size() < 2; k++) @(negedge i_clk);
        @(posedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        chk("areset valid", 32'(bus.M_VALID), 32'd0);
        chk("areset busy", 32'(o_busy), 32'd0);
        chk("areset fifo_rd", 32'(bus.o_fifo_rd), 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("areset no done", 32'(done_cnt - d0), 32'd0);
        chk("areset no abort", 32'(ab_cnt - a0), 32'd0);
        chk("areset stays idle", 32'(o_busy), 32'd0);
        do_flush();

        chk("valid only when busy", 32'(idle_err), 32'd0);
        chk("stream stable", 32'(stab_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
